// File: rtl/load_store_ctrl.sv
// ----------------------------------------------------------------------------
// load_store_ctrl
//
// Runs one data-memory access for each core load/store request. It checks the
// command and its alignment, then drives a request/ack handshake with the data
// memory and waits out any wait-states. Store data and byte enables are moved
// to the addressed byte lane. Load data is taken from that lane and then sign-
// or zero-extended according to funct3 (LB/LH/LW/LBU/LHU).
//
// The core holds its pipeline while busy is high.
//
// Parameters
//   TIMEOUT   : maximum number of ACCESS cycles without memAck before the
//               access is aborted (must be >= 2)
//   CNT_W     : width of the wait counter (must be able to hold TIMEOUT)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   core request strobe, looked at only in IDLE
//   we         in   1 = store, 0 = load
//   funct3     in   RISC-V size/sign code
//   addr       in   byte address
//   wdata      in   store data, value in the low bits
//   busy       out  high whenever the controller is not IDLE
//   done       out  one-cycle completion pulse
//   err        out  valid with done: misaligned, illegal funct3 or timeout
//   rdata      out  extended load result, held until the next done
//   memReq     out  memory request, held until ack or abort
//   memWe      out  memory write enable
//   memAddr    out  word address
//   memByteEn  out  byte-lane enables
//   memWdata   out  lane-shifted store data
//   memRdata   in   memory read word
//   memAck     in   memory completion, looked at only in ACCESS
// ----------------------------------------------------------------------------
module load_store_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        memReq,
   output logic        memWe,
   output logic [31:0] memAddr,
   output logic [3:0]  memByteEn,
   output logic [31:0] memWdata,
   input  logic [31:0] memRdata,
   input  logic        memAck
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Value of the wait counter on the last ACCESS cycle before an abort.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   // funct3[1:0] gives the access size.
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // -------------------------------------------------------------------------
   // Registered state and outputs
   // -------------------------------------------------------------------------
   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        funct3_q;    // size/sign code of the access in flight
   logic [1:0]        lane_q;      // addr[1:0] of the access in flight
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic [31:0]       rdata_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [31:0]       mem_addr_q;
   logic [3:0]        mem_be_q;
   logic [31:0]       mem_wdata_q;

   // -------------------------------------------------------------------------
   // Command decode on the incoming request
   // -------------------------------------------------------------------------
   logic        cmd_legal;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;

   // NOTE: every signal assigned in an always_comb gets a default value first.
   // Otherwise any path that does not assign it infers a latch.
   always_comb begin
      cmd_legal = 1'b1;

      if (we) begin
         // Stores support only SB/SH/SW.
         if (funct3[2] || (funct3[1:0] == 2'b11)) begin
            cmd_legal = 1'b0;
         end
      end else begin
         // Loads support LB/LH/LW/LBU/LHU. 011, 110 and 111 are not valid.
         if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)) begin
            cmd_legal = 1'b0;
         end
      end

      // Natural alignment: a half must be on an even address, a word on a
      // multiple of four.
      if ((funct3[1:0] == SZ_HALF) && addr[0]) begin
         cmd_legal = 1'b0;
      end
      if ((funct3[1:0] == SZ_WORD) && (addr[1:0] != 2'b00)) begin
         cmd_legal = 1'b0;
      end
   end

   always_comb begin
      be_calc = 4'b1111;
      unique case (funct3[1:0])
         SZ_BYTE: be_calc = 4'b0001 << addr[1:0];
         SZ_HALF: be_calc = 4'b0011 << addr[1:0];
         default: be_calc = 4'b1111;
      endcase
   end

   // The store value is moved up to its byte lane. Bits shifted past bit 31
   // are never enabled, so dropping them is safe.
   assign wdata_calc = wdata << {addr[1:0], 3'b000};

   // -------------------------------------------------------------------------
   // Load data: take the addressed lane, then extend it
   // -------------------------------------------------------------------------
   logic [31:0] lane_data;
   logic [31:0] load_ext;

   assign lane_data = memRdata >> {lane_q, 3'b000};

   always_comb begin
      load_ext = lane_data;
      unique case (funct3_q)
         3'b000:  load_ext = {{24{lane_data[7]}},  lane_data[7:0]};   // LB
         3'b001:  load_ext = {{16{lane_data[15]}}, lane_data[15:0]};  // LH
         3'b100:  load_ext = {24'h000000, lane_data[7:0]};            // LBU
         3'b101:  load_ext = {16'h0000,   lane_data[15:0]};           // LHU
         default: load_ext = lane_data;                               // LW
      endcase
   end

   // -------------------------------------------------------------------------
   // Sequencer
   // -------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments only.
   // Every register then samples pre-edge values, whatever order the
   // statements appear in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         funct3_q    <= 3'b000;
         lane_q      <= 2'b00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= 32'h0000_0000;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0000_0000;
         mem_be_q    <= 4'b0000;
         mem_wdata_q <= 32'h0000_0000;
      end else begin
         // done is a single-cycle pulse. Only the transition into DONE raises it.
         done_q <= 1'b0;

         unique case (state_q)
            ST_IDLE: begin
               if (req) begin
                  busy_q   <= 1'b1;
                  funct3_q <= funct3;
                  lane_q   <= addr[1:0];
                  if (cmd_legal) begin
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= we;
                     mem_addr_q  <= {addr[31:2], 2'b00};
                     mem_be_q    <= be_calc;
                     mem_wdata_q <= wdata_calc;
                     cnt_q       <= '0;
                     state_q     <= ST_ACCESS;
                  end else begin
                     // Rejected before it reaches memory. memReq stays low.
                     err_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end

            ST_ACCESS: begin
               // The ack is checked before the timeout, so an ack on the last
               // allowed cycle still completes without error.
               if (memAck) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  if (!mem_we_q) begin
                     rdata_q <= load_ext;
                  end
                  err_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (cnt_q == CNT_LAST) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  err_q     <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_DONE: begin
               busy_q  <= 1'b0;
               err_q   <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               busy_q    <= 1'b0;
               err_q     <= 1'b0;
               mem_req_q <= 1'b0;
               mem_we_q  <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: every output comes directly from a register
   // -------------------------------------------------------------------------
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign memReq    = mem_req_q;
   assign memWe     = mem_we_q;
   assign memAddr   = mem_addr_q;
   assign memByteEn = mem_be_q;
   assign memWdata  = mem_wdata_q;

endmodule
